// File: rtl/rom_arb_pkg.sv
// Shared types for the two-port ROM arbiter.
// State encoding, owner encoding, grant vectors and default widths.
package rom_arb_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOK = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } owner_t;

    localparam logic [1:0] GNT_IF = 2'b01;
    localparam logic [1:0] GNT_LD = 2'b10;

endpackage

// File: rtl/rom_arb_pick.sv
// Grant selection between fetch and load requesters.
// ROM_ARB_RR_EN selects round-robin; otherwise load has fixed priority.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic       if_valid,
    input  logic       ld_valid,
    input  owner_t     last,
    output logic [1:0] gnt
);

`ifdef ROM_ARB_RR_EN
    always_comb begin
        gnt = '0;
        unique case (1'b1)
            (if_valid & ld_valid):  gnt = (last == OWN_LD) ? GNT_IF : GNT_LD;
            (ld_valid & ~if_valid): gnt = GNT_LD;
            (if_valid & ~ld_valid): gnt = GNT_IF;
            default:                gnt = '0;
        endcase
    end
`else
    logic unused_last;
    assign unused_last = (last == OWN_LD);

    always_comb begin
        gnt = '0;
        unique case (1'b1)
            ld_valid:               gnt = GNT_LD;
            (if_valid & ~ld_valid): gnt = GNT_IF;
            default:                gnt = '0;
        endcase
    end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates fetch and load ports onto one combinational ROM, one transaction at a time.
// Define ROM_ARB_RR_EN for round-robin arbitration (default: load over fetch).
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_rsp_valid,
    input  logic              ld_rsp_ready,
    output logic [DATA_W-1:0] ld_rsp_data,
    output logic              ld_rsp_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              rom_rst_n
);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    owner_t            last;
    logic [1:0]        gnt;
    logic              accept;
    logic              rsp_hs;
    logic              misal;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    rom_arb_pick u_pick (
        .if_valid (if_req_valid),
        .ld_valid (ld_req_valid),
        .last     (last),
        .gnt      (gnt)
    );

    assign accept = (state == IDLE) & ~rst & (|gnt);
    assign rsp_hs = (owner == OWN_IF) ? if_rsp_ready : ld_rsp_ready;
    assign misal  = |addr_q[1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = LOOK;
            LOOK:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if_req_ready = accept & gnt[0];
        ld_req_ready = accept & gnt[1];
        if_rsp_valid = (state == RESP) & (owner == OWN_IF);
        ld_rsp_valid = (state == RESP) & (owner == OWN_LD);
        if_rsp_data  = (owner == OWN_IF) ? data_q : '0;
        ld_rsp_data  = (owner == OWN_LD) ? data_q : '0;
        if_rsp_err   = (owner == OWN_IF) & err_q;
        ld_rsp_err   = (owner == OWN_LD) & err_q;
    end

    // The latched address doubles as rom_addr, so it only moves on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner  <= OWN_IF;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                owner  <= gnt[1] ? OWN_LD : OWN_IF;
                addr_q <= gnt[1] ? ld_req_addr : if_req_addr;
            end
            if (state == LOOK) begin
                err_q  <= misal;
                data_q <= misal ? '0 : rom_data;
            end
        end
    end

`ifdef ROM_ARB_RR_EN
    owner_t last_q;

    always_ff @(posedge clk) begin
        if (rst)         last_q <= OWN_LD;
        else if (accept) last_q <= gnt[1] ? OWN_LD : OWN_IF;
    end

    assign last = last_q;
`else
    assign last = OWN_LD;
`endif

    assign rom_addr  = addr_q;
    assign rom_rst_n = ~rst;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: vector table plus stall/reset/arbitration sequences.
// Expected grant order follows ROM_ARB_RR_EN when it is defined.
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready;
    logic [6:0]  if_req_addr;
    logic        if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_rsp_data;
    logic        ld_req_valid, ld_req_ready;
    logic [6:0]  ld_req_addr;
    logic        ld_rsp_valid, ld_rsp_ready, ld_rsp_err;
    logic [31:0] ld_rsp_data;
    logic [6:0]  rom_addr;
    logic [31:0] rom_data;
    logic        rom_rst_n;

    logic [31:0] rom [32];
    int          tests = 0;
    int          fails = 0;
    bit          last_ld = 1'b1;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr[6:2]];

    rom_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_req_addr  (ld_req_addr),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_ready (ld_rsp_ready),
        .ld_rsp_data  (ld_rsp_data),
        .ld_rsp_err   (ld_rsp_err),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .rom_rst_n    (rom_rst_n)
    );

    typedef struct {
        bit          ld;
        logic [6:0]  addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit pick_ld(input bit iv, input bit lv);
`ifdef ROM_ARB_RR_EN
        if (iv && lv) return !last_ld;
        return lv;
`else
        return lv | (iv & 1'b0);
`endif
    endfunction

    // Starts at posedge+1 with requests driven; returns at posedge+1 in IDLE.
    task automatic txn(input bit exp_ld, input logic [31:0] exp_d,
                       input logic exp_e, input logic [6:0] exp_a,
                       input bit drop);
        #1;
        chk("if_req_ready", if_req_ready, !exp_ld);
        chk("ld_req_ready", ld_req_ready, exp_ld);
        @(posedge clk); #1;
        last_ld = exp_ld;
        if (drop) begin
            if (exp_ld) ld_req_valid = 1'b0;
            else        if_req_valid = 1'b0;
        end
        #1;
        chk("look_rdy", {if_req_ready, ld_req_ready}, 2'b00);
        chk("look_rom_addr", rom_addr, exp_a);
        chk("look_rsp_valid", {if_rsp_valid, ld_rsp_valid}, 2'b00);
        @(posedge clk); #2;
        if (exp_ld) begin
            chk("ld_rsp_valid", ld_rsp_valid, 1);
            chk("ld_rsp_data", ld_rsp_data, exp_d);
            chk("ld_rsp_err", ld_rsp_err, exp_e);
            chk("if_rsp_valid_nonowner", if_rsp_valid, 0);
            chk("if_rsp_data_nonowner", if_rsp_data, 0);
        end else begin
            chk("if_rsp_valid", if_rsp_valid, 1);
            chk("if_rsp_data", if_rsp_data, exp_d);
            chk("if_rsp_err", if_rsp_err, exp_e);
            chk("ld_rsp_valid_nonowner", ld_rsp_valid, 0);
            chk("ld_rsp_data_nonowner", ld_rsp_data, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit w;
        for (int i = 0; i < 32; i++) rom[i] = 32'hA5A5_0000 + i;
        rom[0] = 32'h0000_0013;
        rom[6] = 32'h0bb0_0613;
        rom[7] = 32'h0b50_0513;

        vecs[0] = '{0, 7'h18, 32'h0bb00613, 0};
        vecs[1] = '{1, 7'h1C, 32'h0b500513, 0};
        vecs[2] = '{1, 7'h1A, 32'h00000000, 1};
        vecs[3] = '{0, 7'h01, 32'h00000000, 1};
        vecs[4] = '{0, 7'h00, 32'h00000013, 0};
        vecs[5] = '{1, 7'h7C, 32'hA5A5001F, 0};
        vecs[6] = '{0, 7'h40, 32'hA5A50010, 0};
        vecs[7] = '{1, 7'h03, 32'h00000000, 1};

        rst = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 7'h18;
        ld_req_valid = 1'b1; ld_req_addr = 7'h1C;
        if_rsp_ready = 1'b1; ld_rsp_ready = 1'b1;

        // Reset: readies stay low even with requests pending.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rdy", {if_req_ready, ld_req_ready}, 2'b00);
        chk("rst_rom_rst_n", rom_rst_n, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        if_req_valid = 1'b0;
        ld_req_valid = 1'b0;
        #1;
        chk("rst_rsp_valid", {if_rsp_valid, ld_rsp_valid}, 2'b00);
        chk("rst_if_data", if_rsp_data, 0);
        chk("rst_ld_data", ld_rsp_data, 0);
        chk("rst_err", {if_rsp_err, ld_rsp_err}, 2'b00);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_rst_n", rom_rst_n, 1);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            if (vecs[i].ld) begin
                ld_req_valid = 1'b1; ld_req_addr = vecs[i].addr;
            end else begin
                if_req_valid = 1'b1; if_req_addr = vecs[i].addr;
            end
            txn(vecs[i].ld, vecs[i].data, vecs[i].err, vecs[i].addr, 1'b1);
        end

        // Simultaneous requests: winner first, loser stays pending.
        if_req_addr = 7'h18; ld_req_addr = 7'h1C;
        if_req_valid = 1'b1; ld_req_valid = 1'b1;
        w = pick_ld(1, 1);
        txn(w, w ? 32'h0b500513 : 32'h0bb00613, 0, w ? 7'h1C : 7'h18, 1'b1);
        txn(!w, !w ? 32'h0b500513 : 32'h0bb00613, 0, !w ? 7'h1C : 7'h18, 1'b1);

        // Continuous requests on both ports for two rounds.
        if_req_valid = 1'b1; ld_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = pick_ld(1, 1);
            txn(w, w ? 32'h0b500513 : 32'h0bb00613, 0, w ? 7'h1C : 7'h18, 1'b0);
        end
        if_req_valid = 1'b0; ld_req_valid = 1'b0;
        @(posedge clk); #1;

        // Response stall: held data, no new grants, then release to IDLE.
        ld_req_addr = 7'h18; ld_req_valid = 1'b1; ld_rsp_ready = 1'b0;
        #1;
        chk("stall_ld_rdy", ld_req_ready, 1);
        @(posedge clk); #1;
        last_ld = 1'b1;
        ld_req_valid = 1'b0;
        if_req_addr = 7'h1C; if_req_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_valid", ld_rsp_valid, 1);
            chk("stall_data", ld_rsp_data, 32'h0bb00613);
            chk("stall_rdy", {if_req_ready, ld_req_ready}, 2'b00);
            chk("stall_rom_addr", rom_addr, 7'h18);
            @(posedge clk); #1;
        end
        ld_rsp_ready = 1'b1;
        @(posedge clk); #2;
        chk("release_valid", ld_rsp_valid, 0);
        chk("release_if_rdy", if_req_ready, 1);
        chk("idle_rom_addr", rom_addr, 7'h18);
        if_req_valid = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("drop_no_rsp", {if_rsp_valid, ld_rsp_valid}, 2'b00);
            chk("drop_rom_addr", rom_addr, 7'h18);
            @(posedge clk); #1;
        end

        // Reset while in LOOK aborts the transaction.
        if_req_addr = 7'h18; if_req_valid = 1'b1;
        #1;
        chk("abort_if_rdy", if_req_ready, 1);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_ld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("abort_no_rsp", {if_rsp_valid, ld_rsp_valid}, 2'b00);
            @(posedge clk); #1;
        end
        if_req_addr = 7'h00; if_req_valid = 1'b1;
        txn(0, 32'h00000013, 0, 7'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
